// File: rtl/enemy_pkg.sv
// Shared enemy-side types and constants.
// Used by the fire scheduler and the level/HUD logic.
package enemy_pkg;

  typedef enum logic [1:0] {
    COOL,
    SEARCH,
    GRANT,
    WAIT
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [2:0] MAX_LEVEL = 3'd7;

  function automatic logic [4:0] popcount16(
    input logic [15:0] v
  );
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, advances when en is high.
// Feeds the cooldown jitter of the fire scheduler.
import enemy_pkg::*;

module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] r_q;

  // shift left, feedback is the parity of the tapped bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= LFSR_SEED;
    end else if (en) begin
      r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/en_fire_sched.sv
// Enemy fire scheduler: one round-robin missile grant
// per cooldown window, capped by missiles in flight.
import enemy_pkg::*;

module en_fire_sched #(
  parameter int N             = 4,
  parameter int BASE_COOLDOWN = 60,
  parameter int STEP          = 6,
  parameter int MIN_COOLDOWN  = 12,
  parameter int MAX_INFLIGHT  = 2,
  parameter int JITTER        = 1,
  localparam int W            = $clog2(N)
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         frame_tick,
  input  logic         level_change,
  input  logic [N-1:0] alive,
  input  logic [N-1:0] busy,
  output logic [N-1:0] fire_grant,
  output logic [W-1:0] grant_idx,
  output logic [2:0]   level,
  output logic         all_dead
);

  state_t       r_state;
  logic [7:0]   r_cnt;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_scan;
  logic [W-1:0] r_scanned;
  logic [2:0]   r_level;
  logic [N-1:0] r_fire;
  logic [W-1:0] r_gidx;
  logic         r_all_dead;

  logic [7:0]   w_lfsr;
  logic [4:0]   w_busy_cnt;
  logic         w_elig;
  logic [W-1:0] w_scan_nx;
  logic [N-1:0] w_onehot;
  logic [2:0]   w_lvl_next;

  lfsr8 u_lfsr (
    .clk (pclk),
    .rst (rst),
    .en  (frame_tick),
    .q   (w_lfsr)
  );

  // floor applied in 9 bits so a large step*level
  // underflows to the floor instead of wrapping
  function automatic logic [7:0] f_cool(
    input logic [2:0] lvl,
    input logic [7:0] rnd
  );
    logic [7:0] step_lvl;
    logic [8:0] raw;
    logic [7:0] base;
    step_lvl = 8'(STEP * int'(lvl));
    raw = {1'b0, 8'(BASE_COOLDOWN)} - {1'b0, step_lvl};
    if (raw[8] || raw < 9'(MIN_COOLDOWN)) begin
      base = 8'(MIN_COOLDOWN);
    end else begin
      base = raw[7:0];
    end
    if (JITTER != 0) begin
      base = base + {6'd0, rnd[1:0]};
    end
    return base;
  endfunction

  assign w_busy_cnt = popcount16(16'(busy));
  assign w_elig     = alive[r_scan] & ~busy[r_scan]
                    & (w_busy_cnt < 5'(MAX_INFLIGHT));
  assign w_scan_nx  = (r_scan == W'(N - 1)) ? '0
                    : r_scan + 1'b1;
  assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << r_scan;
  assign w_lvl_next = (r_level < MAX_LEVEL) ? r_level + 3'd1
                    : r_level;

  // scheduler FSM; level_change overrides every state
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state   <= COOL;
      r_cnt     <= 8'(BASE_COOLDOWN);
      r_ptr     <= '0;
      r_scan    <= '0;
      r_scanned <= '0;
      r_level   <= '0;
      r_fire    <= '0;
      r_gidx    <= '0;
    end else begin
      r_fire <= '0;
      if (level_change) begin
        r_level <= w_lvl_next;
        r_ptr   <= '0;
        r_cnt   <= f_cool(w_lvl_next, w_lfsr);
        r_state <= COOL;
      end else begin
        unique case (r_state)
          COOL: begin
            if (frame_tick) begin
              if (r_cnt == 8'd1) begin
                r_state   <= SEARCH;
                r_scan    <= r_ptr;
                r_scanned <= '0;
              end else begin
                r_cnt <= r_cnt - 8'd1;
              end
            end
          end
          SEARCH: begin
            if (w_elig) begin
              r_state <= GRANT;
              r_fire  <= w_onehot;
              r_gidx  <= r_scan;
              r_ptr   <= w_scan_nx;
            end else if (r_scanned == W'(N - 1)) begin
              r_state <= WAIT;
            end else begin
              r_scan    <= w_scan_nx;
              r_scanned <= r_scanned + 1'b1;
            end
          end
          GRANT: begin
            r_cnt   <= f_cool(r_level, w_lfsr);
            r_state <= COOL;
          end
          WAIT: begin
            if (frame_tick) begin
              r_state   <= SEARCH;
              r_scan    <= r_ptr;
              r_scanned <= '0;
            end
          end
          default: r_state <= COOL;
        endcase
      end
    end
  end

  // registered all-dead flag
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_all_dead <= 1'b0;
    end else begin
      r_all_dead <= ~|alive;
    end
  end

  assign fire_grant = r_fire;
  assign grant_idx  = r_gidx;
  assign level      = r_level;
  assign all_dead   = r_all_dead;

endmodule

// File: tb/tb_en_fire_sched.sv
// Self-checking bench for en_fire_sched.
// Frame-level reference model, directed + random frames.
module tb_en_fire_sched;

  localparam int N = 4;
  localparam int BASE = 3;
  localparam int STEP = 1;
  localparam int MINC = 1;
  localparam int MAXF = 2;
  localparam int FLEN = 20;

  logic       pclk;
  logic       rst;
  logic       frame_tick;
  logic       level_change;
  logic [3:0] alive;
  logic [3:0] busy;
  logic [3:0] fire_grant;
  logic [1:0] grant_idx;
  logic [2:0] level;
  logic       all_dead;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int  m_ptr;
  int  m_level;
  int  m_cool;
  bit  m_wait;
  int  m_gidx;

  en_fire_sched #(
    .N             (N),
    .BASE_COOLDOWN (BASE),
    .STEP          (STEP),
    .MIN_COOLDOWN  (MINC),
    .MAX_INFLIGHT  (MAXF),
    .JITTER        (0)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .level_change (level_change),
    .alive        (alive),
    .busy         (busy),
    .fire_grant   (fire_grant),
    .grant_idx    (grant_idx),
    .level        (level),
    .all_dead     (all_dead)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  function automatic int cooldown(input int lvl);
    int c;
    c = BASE - STEP * lvl;
    return (c < MINC) ? MINC : c;
  endfunction

  // offset from ptr of the first enemy allowed to fire, -1 if none
  function automatic int first_elig();
    int nb;
    nb = 0;
    for (int i = 0; i < N; i++) nb += int'(busy[i]);
    if (nb >= MAXF) return -1;
    for (int k = 0; k < N; k++) begin
      if (alive[(m_ptr + k) % N] && !busy[(m_ptr + k) % N])
        return k;
    end
    return -1;
  endfunction

  function automatic bit search_next();
    return m_wait || (m_cool == 1);
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_level = 0;
    m_cool  = BASE;
    m_wait  = 0;
    m_gidx  = 0;
  endtask

  // one frame: tick at the start, optional level pulse either
  // mid-frame (lc_mid) or on the first search examination (lc_hit)
  task automatic run_frame(input bit lc_mid, input bit lc_hit,
                           input string tag);
    int k;
    int idx;
    int exp_j;
    int exp_n;
    logic [3:0] exp_v;
    int obs_j;
    int obs_n;
    logic [3:0] obs_v;
    exp_j = 0;
    exp_n = 0;
    exp_v = '0;
    if (search_next()) begin
      k = first_elig();
      if (lc_hit) begin
        m_wait = 0;
      end else if (k >= 0) begin
        idx    = (m_ptr + k) % N;
        exp_j  = 2 + k;
        exp_n  = 1;
        exp_v  = 4'(1 << idx);
        m_gidx = idx;
        m_ptr  = (idx + 1) % N;
        m_cool = cooldown(m_level);
        m_wait = 0;
      end else begin
        m_wait = 1;
      end
    end else begin
      m_cool--;
    end
    if (lc_mid || lc_hit) begin
      m_level = (m_level < 7) ? m_level + 1 : 7;
      m_ptr   = 0;
      m_cool  = cooldown(m_level);
      m_wait  = 0;
    end
    obs_j = 0;
    obs_n = 0;
    obs_v = '0;
    frame_tick = 1'b1;
    for (int j = 1; j <= FLEN; j++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (j == 1) begin
        frame_tick = 1'b0;
        if (lc_hit) level_change = 1'b1;
      end
      if (j == 2 && lc_hit) level_change = 1'b0;
      if (j == 10 && lc_mid) level_change = 1'b1;
      if (j == 11 && lc_mid) level_change = 1'b0;
      if (fire_grant !== 4'b0) begin
        obs_n++;
        if (obs_j == 0) begin
          obs_j = j;
          obs_v = fire_grant;
        end
      end
    end
    chk({tag, ".grant"},
        {8'(obs_n), 8'(obs_j), 12'd0, obs_v},
        {8'(exp_n), 8'(exp_j), 12'd0, exp_v});
    chk({tag, ".idx"}, 32'(grant_idx), 32'(m_gidx));
    chk({tag, ".level"}, 32'(level), 32'(m_level));
    chk({tag, ".dead"}, 32'(all_dead), 32'(alive == 4'b0));
  endtask

  task automatic frames_until_search(input string tag);
    int guard;
    guard = 0;
    while (!search_next() && guard < 20) begin
      run_frame(0, 0, tag);
      guard++;
    end
    chk({tag, ".reach"}, 32'(search_next()), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".fire"}, 32'(fire_grant), 32'd0);
    chk({tag, ".idx"}, 32'(grant_idx), 32'd0);
    chk({tag, ".level"}, 32'(level), 32'd0);
    chk({tag, ".dead"}, 32'(all_dead), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    frame_tick   = 1'b0;
    level_change = 1'b0;
    alive        = 4'b0;
    busy         = 4'b0;
    model_reset();
    repeat (3) @(negedge pclk);
    check_reset_outputs("rst0");
    rst = 1'b0;

    // all alive, nothing in flight
    alive = 4'b1111;
    busy  = 4'b0000;
    for (int f = 0; f < 7; f++) run_frame(0, 0, "s1");

    // two live enemies alternate
    alive = 4'b1010;
    for (int f = 0; f < 9; f++) run_frame(0, 0, "s2");

    // in-flight cap reached -> WAIT, then relieved
    alive = 4'b1111;
    busy  = 4'b0011;
    frames_until_search("s3a");
    run_frame(0, 0, "s3b");
    run_frame(0, 0, "s3c");
    busy = 4'b0010;
    for (int f = 0; f < 4; f++) run_frame(0, 0, "s3d");
    busy = 4'b0000;

    // level pulse collides with the first examination
    frames_until_search("s4a");
    run_frame(0, 1, "s4b");
    for (int f = 0; f < 5; f++) run_frame(0, 0, "s4c");

    // level saturation and cooldown floor
    for (int f = 0; f < 8; f++) run_frame(1, 0, "s5a");
    for (int f = 0; f < 5; f++) run_frame(0, 0, "s5b");

    // all dead: never grants
    alive = 4'b0000;
    for (int f = 0; f < 3; f++) run_frame(0, 0, "s7");

    // random alive/busy with occasional level pulses
    for (int f = 0; f < 40; f++) begin
      alive = 4'($urandom_range(0, 15));
      busy  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      run_frame($urandom_range(0, 7) == 0, 0, "rnd");
    end

    // asynchronous reset in the middle of a search
    busy  = 4'b0000;
    alive = 4'b1111;
    run_frame(1, 0, "s6pre");
    frames_until_search("s6a");
    alive = 4'(1 << ((m_ptr + 3) % N));
    frame_tick = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    frame_tick = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("s6rst");
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    alive = 4'b1111;
    for (int f = 0; f < 7; f++) run_frame(0, 0, "s6post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/en_fire_sched.md
# en_fire_sched

Enemy fire scheduler. It shares the enemy-missile resource between N enemy instances: one grant per cooldown window, round-robin fairness, a cap on missiles in flight, and a cooldown that shortens as the level rises. It sits beside the row of enemy instances and drives each instance's missile-fire enable in place of a constant-1 fire button.

## Interface
- N, 4: number of enemies (2..16); W = $clog2(N)
- BASE_COOLDOWN, 60: frames between grants at level 0 (8-bit)
- STEP, 6: frames removed per level
- MIN_COOLDOWN, 12: cooldown floor in frames
- MAX_INFLIGHT, 2: maximum concurrent enemy missiles
- JITTER, 1: 1 adds 0..3 pseudo-random frames to each cooldown; 0 disables it
- pclk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame (vsync edge)
- level_change  in  1  one-cycle pulse on level advance
- alive  in  N  per-enemy alive flags
- busy  in  N  per-enemy missile in flight
- fire_grant  out  N  one-hot fire pulse, one cycle
- grant_idx  out  W  index of the last grant
- level  out  3  current level, saturates at 7
- all_dead  out  1  registered; equals ~|alive

## Operation
- States: COOL, SEARCH, GRANT, WAIT.
- Reset:
  - State enters COOL with cnt = BASE_COOLDOWN, giving an initial grace period.
  - ptr = 0, level = 0, LFSR = 8'hA5.
  - fire_grant = 0, grant_idx = 0, all_dead = 0.
- COOL:
  - Each frame_tick decrements cnt.
  - A frame_tick that arrives with cnt == 1 moves the block to SEARCH, with scan = ptr and scanned = 0.
- SEARCH:
  - One index is examined per cycle. Index i is eligible when alive[i] & ~busy[i] & (popcount(busy) < MAX_INFLIGHT).
  - If eligible: go to GRANT and latch gidx = i.
  - If not eligible: scan = scan+1 mod N, scanned+1.
  - After N indices with no eligible enemy: go to WAIT.
- GRANT (one cycle):
  - fire_grant = 1<<gidx and grant_idx = gidx.
  - ptr = gidx+1 mod N.
  - cnt = max(BASE_COOLDOWN − STEP·level, MIN_COOLDOWN) + (JITTER ? LFSR[1:0] : 0).
  - Next state is COOL.
- WAIT:
  - On frame_tick, go to SEARCH with scan = ptr. There is no cooldown reload.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances once per frame_tick in every state.
- level_change (highest priority, in any state):
  - level = min(level+1, 7), ptr = 0.
  - Next state COOL, with cnt reloaded from the new level (jitter included).
  - A GRANT that would have occurred in the same cycle is suppressed: fire_grant stays 0.
- Arithmetic:
  - Cooldown is computed in 9 bits before the floor is applied.
  - STEP·level is computed in 8 bits.
  - cnt is 8 bits and never reloads to 0. MIN_COOLDOWN ≥ 1 is required.

## Timing
- fire_grant is registered, high for exactly one cycle, and at most one bit is set.
- SEARCH entry to grant: k+1 cycles, where k is the offset of the first eligible index from ptr. Worst case is N cycles.
- SEARCH always completes within N cycles. The bound is frame-tick–independent; the required minimum frame length is far greater than N.
- A frame_tick arriving in SEARCH or GRANT is ignored for state purposes, but the LFSR still advances.
- alive and busy are sampled in the cycle of examination. Changes after that point do not revoke a pending GRANT.
- all_dead: one cycle of latency from alive.
- When all enemies are dead, the block cycles WAIT→SEARCH→WAIT and never grants.

## Structure
- Shared package enemy_pkg holds:
  - the state enum (COOL, SEARCH, GRANT, WAIT);
  - LFSR_SEED = 8'hA5 and the LFSR tap mask;
  - the MAX_LEVEL = 7 constant, to be reused by the level/HUD logic.
- One sub-module, lfsr8: clock, reset, advance enable, 8-bit output.
- Popcount of busy is a combinational function placed in enemy_pkg.

## Test plan
All scenarios use N=4, JITTER=0, BASE_COOLDOWN=3, STEP=1, MIN_COOLDOWN=1, MAX_INFLIGHT=2, with a frame_tick every 20 cycles.
- Reset release, alive=4'b1111, busy=0:
  - fire_grant=4'b0001 appears 1 cycle after the 3rd frame_tick, then grant_idx=0.
  - The next grant is 4'b0010, three ticks later.
- alive=4'b1010, busy=0:
  - Grants alternate 4'b0010, 4'b1000, 4'b0010.
  - Each grant from SEARCH entry follows the k+1 latency: the grant to enemy 1 lands 2 cycles after entry when ptr=0.
- busy=4'b0011, alive=4'b1111:
  - No grant; the block enters WAIT.
  - Clearing busy[0] before the next tick makes the next SEARCH grant 4'b0001 or the next eligible index from ptr.
- level_change asserted in the same cycle SEARCH finds an eligible enemy:
  - fire_grant stays 0 and level=1.
  - Cooldown reloads to 2, so the next grant comes two ticks later.
- Eight level_change pulses:
  - level saturates at 7.
  - Cooldown stays at the floor of 1: a grant follows every tick.
- Assert rst mid-SEARCH:
  - All outputs go to 0 immediately (asynchronously).
  - After release the block behaves as in scenario 1.
